// File: rtl/boot_fetch_sel_pkg.sv
// Shared types and constants for the boot fetch selector.
package boot_fetch_sel_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RUN    = 2'd2,
    ST_REBOOT = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            fault;
  } fetch_rsp_t;

  // Counter width able to hold 0 .. timeout-1.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/boot_fetch_sel_if.sv
// Instruction-fetch port between the core (master) and the fetch selector (slave).
interface boot_fetch_sel_if;
  import boot_fetch_sel_pkg::*;

  logic            fetch_req;
  logic [XLEN-1:0] fetch_addr;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_data;
  logic            fetch_fault;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_data, fetch_fault
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_data, fetch_fault
  );

endinterface

// File: rtl/boot_fetch_sel_watchdog.sv
// Boot watchdog: counts enabled cycles and flags the last allowed one.
module boot_watchdog
  import boot_fetch_sel_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned W = wd_width(TIMEOUT);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + W'(1);
    end
  end

  assign expire_c = en && (count_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/boot_fetch_sel.sv
// Routes core fetches to the start-up ROM during boot, then permanently to IMEM.
// Optional BOOT_FETCH_SEL_REBOOT_EN adds a reboot input that returns RUN to BOOT.
module boot_fetch_sel
  import boot_fetch_sel_pkg::*;
#(
  parameter int unsigned IMEM_AW      = 10,
  parameter int unsigned BOOT_TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  boot_fetch_sel_if.slave     fetch,
  output logic [XLEN-1:0]     rom_addr,
  input  logic [XLEN-1:0]     rom_data,
  input  logic                rom_done,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic                imem_en,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                boot_mode,
  output logic                boot_error
`ifdef BOOT_FETCH_SEL_REBOOT_EN
  ,
  input  logic                reboot
`endif
);

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       boot_mode_q, boot_mode_d;
  logic       boot_error_q, boot_error_d;
  logic       valid_q, valid_d;
  logic       imem_sel_q, imem_sel_d;
  fetch_rsp_t rsp_q, rsp_d;

  logic accept_c;
  logic addr_bad_c;
  logic wd_expire_c;
  logic reboot_c;

`ifdef BOOT_FETCH_SEL_REBOOT_EN
  assign reboot_c = reboot;
`else
  assign reboot_c = 1'b0;
`endif

  assign accept_c   = fetch.fetch_req && ready_q;
  assign addr_bad_c = (fetch.fetch_addr[1:0] != 2'b00) ||
                      ((fetch.fetch_addr >> (IMEM_AW + 2)) != '0);

  boot_watchdog #(
    .TIMEOUT (BOOT_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == ST_REBOOT),
    .en       (state_q == ST_BOOT),
    .expire_c (wd_expire_c)
  );

  // Next state, IMEM request and next registered response.
  always_comb begin
    state_d      = state_q;
    boot_error_d = boot_error_q;
    valid_d      = 1'b0;
    rsp_d        = '{data: rsp_q.data, fault: 1'b0};
    imem_sel_d   = 1'b0;
    imem_en      = 1'b0;
    imem_addr    = fetch.fetch_addr[IMEM_AW+1:2];

    case (state_q)
      ST_BOOT: begin
        if (rom_done) begin
          state_d = ST_DRAIN;
        end else if (wd_expire_c) begin
          state_d      = ST_DRAIN;
          boot_error_d = 1'b1;
        end
        if (accept_c) begin
          valid_d = 1'b1;
          rsp_d   = '{data: rom_data, fault: 1'b0};
        end
      end
      ST_DRAIN: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (reboot_c) begin
          state_d = ST_REBOOT;
        end
        if (accept_c) begin
          valid_d = 1'b1;
          if (addr_bad_c) begin
            rsp_d = '{data: NOP_INSN, fault: 1'b1};
          end else begin
            imem_en    = 1'b1;
            imem_sel_d = 1'b1;
          end
        end
      end
      ST_REBOOT: begin
        state_d = ST_BOOT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Ready and boot_mode are registered, so they track the state being entered.
    ready_d     = (state_d == ST_BOOT) || (state_d == ST_RUN);
    boot_mode_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      ready_q      <= 1'b0;
      boot_mode_q  <= 1'b1;
      boot_error_q <= 1'b0;
      valid_q      <= 1'b0;
      imem_sel_q   <= 1'b0;
      rsp_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      boot_mode_q  <= boot_mode_d;
      boot_error_q <= boot_error_d;
      valid_q      <= valid_d;
      imem_sel_q   <= imem_sel_d;
      rsp_q        <= rsp_d;
    end
  end

  // IMEM data arrives one cycle after imem_en, so it is muxed in rather than re-registered.
  assign fetch.fetch_ready = ready_q;
  assign fetch.fetch_valid = valid_q;
  assign fetch.fetch_data  = imem_sel_q ? imem_rdata : rsp_q.data;
  assign fetch.fetch_fault = rsp_q.fault;
  assign rom_addr          = fetch.fetch_addr;
  assign boot_mode         = boot_mode_q;
  assign boot_error        = boot_error_q;

endmodule

// File: tb/tb_boot_fetch_sel.sv
// Randomized bench for boot_fetch_sel with a phase-level reference model.
module tb_boot_fetch_sel;

  localparam int unsigned AW = 10;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [31:0]   addr;
  logic [31:0]   rom_addr, rom_data;
  logic          rom_done;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [31:0]   imem_rdata;
  logic          boot_mode, boot_error;
`ifdef BOOT_FETCH_SEL_REBOOT_EN
  logic          reboot;
  assign reboot = 1'b0;
`endif

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  boot_fetch_sel_if bus();
  assign bus.fetch_req  = req;
  assign bus.fetch_addr = addr;

  boot_fetch_sel #(
    .IMEM_AW      (AW),
    .BOOT_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch      (bus),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_done   (rom_done),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .boot_mode  (boot_mode),
    .boot_error (boot_error)
`ifdef BOOT_FETCH_SEL_REBOOT_EN
    ,
    .reboot     (reboot)
`endif
  );

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h4000_0113;
    return {a[15:0], 16'h0A93} ^ 32'h5A00_0000;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  // Model: phase 0 = fetching from ROM, 1 = one-cycle handoff gap, 2 = fetching from IMEM.
  int          phase;
  bit          fresh, known, m_err;
  int          elapsed;
  bit          e_valid, e_fault;
  logic [31:0] e_data;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'h0);
  endfunction

  // One clock cycle: check outputs against the model, then advance the model over the edge.
  task automatic step();
    bit e_ready, e_en, bad, acc;
    #1;
    e_ready = !fresh && (phase != 1);
    bad     = addr_bad(addr);
    e_en    = (phase == 2) && e_ready && req && !bad;
    if (known) begin
      chk("ready", 32'(bus.fetch_ready), 32'(e_ready));
      chk("boot_mode", 32'(boot_mode), 32'(phase != 2));
      chk("boot_error", 32'(boot_error), 32'(m_err));
      chk("valid", 32'(bus.fetch_valid), 32'(e_valid));
      if (e_valid) begin
        chk("data", bus.fetch_data, e_data);
        chk("fault", 32'(bus.fetch_fault), 32'(e_fault));
      end
      chk("imem_en", 32'(imem_en), 32'(e_en));
      if (e_en) chk("imem_addr", 32'(imem_addr), 32'(addr[AW+1:2]));
    end
    if (rst) begin
      known = 1; fresh = 1; phase = 0; elapsed = 0; m_err = 0;
      e_valid = 0; e_fault = 0; e_data = 32'h0;
    end else if (known) begin
      acc     = req && e_ready;
      e_valid = acc;
      e_fault = 0;
      if (acc) begin
        if (phase == 0) e_data = rom_fn(addr);
        else if (bad) begin e_data = 32'h0000_0013; e_fault = 1; end
        else e_data = mem[addr[AW+1:2]];
      end
      if (phase == 0) begin
        if (rom_done) phase = 1;
        else if (elapsed == int'(TO) - 1) begin phase = 1; m_err = 1; end
        elapsed++;
      end else if (phase == 1) begin
        phase = 2;
      end
      fresh = 0;
    end
    @(negedge clk);
  endtask

  task automatic rand_addr();
    case ($urandom % 8)
      0: addr = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
      1: addr = $urandom | (32'h1 << (AW + 2 + $urandom_range(0, 19)));
      default: addr = {20'h0, $urandom_range(0, (1 << AW) - 1), 2'b00};
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    rst = 1; req = 0; addr = 0; rom_done = 0; known = 0; fresh = 1; phase = 0;
    @(negedge clk);
    step(); step();
    #1;
    chk("rst_ready", 32'(bus.fetch_ready), 32'h0);
    chk("rst_valid", 32'(bus.fetch_valid), 32'h0);
    chk("rst_data", bus.fetch_data, 32'h0);
    chk("rst_boot_mode", 32'(boot_mode), 32'h1);
    chk("rst_imem_en", 32'(imem_en), 32'h0);

    rst = 0; step();
    req = 1; addr = 32'h0; step();
    chk("first_rom_data", bus.fetch_data, 32'h4000_0113);
    chk("first_rom_valid", 32'(bus.fetch_valid), 32'h1);
    repeat (6) begin
      req = 1'($urandom_range(0, 1)); addr = {22'h0, 8'($urandom), 2'b00}; step();
    end
    req = 1; addr = 32'h2c; rom_done = 1; step();
    rom_done = 0; addr = 32'h40;
    #1;
    chk("drain_ready", 32'(bus.fetch_ready), 32'h0);
    chk("drain_valid", 32'(bus.fetch_valid), 32'h1);
    chk("drain_data", bus.fetch_data, 32'h002c_0A93 ^ 32'h5A00_0000);
    step();
    chk("run_boot_mode", 32'(boot_mode), 32'h0);

    addr = 32'h10; #1;
    chk("run_imem_en", 32'(imem_en), 32'h1);
    chk("run_imem_addr", 32'(imem_addr), 32'h4);
    step();
    chk("run_data", bus.fetch_data, mem[4]);
    addr = 32'h1002; step();
    chk("misalign_data", bus.fetch_data, 32'h0000_0013);
    chk("misalign_fault", 32'(bus.fetch_fault), 32'h1);
    addr = 32'h1 << (AW + 2); step();
    chk("range_fault", 32'(bus.fetch_fault), 32'h1);

    repeat (300) begin req = ($urandom % 4) != 0; rand_addr(); step(); end

    req = 1; addr = 32'h20; step();
    rst = 1; step();
    #1;
    chk("rst_mid_valid", 32'(bus.fetch_valid), 32'h0);
    chk("rst_mid_boot", 32'(boot_mode), 32'h1);

    // Watchdog expiry with rom_done held low.
    rst = 0; rom_done = 0;
    repeat (TO - 1) begin req = 1'($urandom_range(0, 1)); addr = 32'($urandom); step(); end
    chk("wd_pre_err", 32'(boot_error), 32'h0);
    step();
    chk("wd_err", 32'(boot_error), 32'h1);
    chk("wd_drain_ready", 32'(bus.fetch_ready), 32'h0);
    repeat (20) begin req = 1; rand_addr(); step(); end
    chk("wd_sticky", 32'(boot_error), 32'h1);
    rst = 1; step();
    chk("wd_cleared", 32'(boot_error), 32'h0);

    // rom_done coinciding with expiry: done wins.
    rst = 0;
    repeat (TO - 1) step();
    rom_done = 1; step();
    rom_done = 0;
    chk("coincide_err", 32'(boot_error), 32'h0);

    repeat (8) begin
      rst = 1; step(); rst = 0;
      repeat (40) begin
        rom_done = ($urandom % 12) == 0;
        req = ($urandom % 3) != 0; rand_addr(); step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
